// File: rtl/clock_divider_bank.sv
// NUM_CH independent programmable dividers off clk. Each channel produces a one-cycle
// tick at terminal count and a 50%-duty usr_clk that toggles on the same edge.
module clock_divider_bank #(
    parameter int          NUM_CH  = 4,
    parameter int          CNT_W   = 28,
    parameter int unsigned DEF_DIV = 25000000,
    parameter bit          RST_EN  = 1'b1,
    localparam int         CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_en,
    input  logic              cfg_oneshot,
    input  logic              sync,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] usr_clk,
    output logic [NUM_CH-1:0] en_status
);

    localparam logic [CNT_W-1:0] DEF_DIV_C = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            // Out-of-range cfg_ch never matches any generated index, so such writes are dropped.
            localparam logic [CH_W-1:0] CH_IDX = CH_W'(gi);

            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic [CNT_W-1:0] div_q, div_d;
            logic             en_q, en_d;
            logic             os_q, os_d;
            logic             uclk_q, uclk_d;
            logic             tick_q, tick_d;
            logic             wr_hit;
            logic             active;
            logic             terminal;

            assign wr_hit   = cfg_we && (cfg_ch == CH_IDX);
            assign active   = en_q && (div_q != '0);
            assign terminal = (cnt_q == (div_q - ONE_C));

            always_comb begin
                cnt_d  = cnt_q;
                div_d  = div_q;
                en_d   = en_q;
                os_d   = os_q;
                uclk_d = uclk_q;
                tick_d = 1'b0;
                if (wr_hit) begin
                    // A write outranks both sync and a coincident terminal count.
                    div_d  = cfg_div;
                    en_d   = cfg_en;
                    os_d   = cfg_oneshot;
                    cnt_d  = '0;
                    uclk_d = 1'b0;
                end else if (sync) begin
                    cnt_d  = '0;
                    uclk_d = 1'b0;
                end else if (active) begin
                    if (terminal) begin
                        cnt_d  = '0;
                        tick_d = 1'b1;
                        uclk_d = ~uclk_q;
                        if (os_q) begin
                            en_d = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + ONE_C;
                    end
                end else begin
                    // Idle channel parks its counter; usr_clk keeps whatever level it reached.
                    cnt_d = '0;
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt_q  <= '0;
                    div_q  <= DEF_DIV_C;
                    en_q   <= RST_EN;
                    os_q   <= 1'b0;
                    uclk_q <= 1'b0;
                    tick_q <= 1'b0;
                end else begin
                    cnt_q  <= cnt_d;
                    div_q  <= div_d;
                    en_q   <= en_d;
                    os_q   <= os_d;
                    uclk_q <= uclk_d;
                    tick_q <= tick_d;
                end
            end

            assign tick[gi]      = tick_q;
            assign usr_clk[gi]   = uclk_q;
            assign en_status[gi] = en_q;
        end
    endgenerate

endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed bench for clock_divider_bank: a 4-channel instance for the main scenarios and a
// 5-channel instance so that an out-of-range channel index is actually encodable.
module tb_clock_divider_bank;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cfg_we = 1'b0;
    logic       cfg_we5 = 1'b0;
    logic [1:0] cfg_ch = 2'd0;
    logic [2:0] cfg_ch5 = 3'd0;
    logic [7:0] cfg_div = 8'd0;
    logic       cfg_en = 1'b0;
    logic       cfg_os = 1'b0;
    logic       sync = 1'b0;
    logic [3:0] tick, usr_clk, en_status;
    logic [4:0] tick5, usr5, en5;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    clock_divider_bank #(.NUM_CH(4), .CNT_W(8), .DEF_DIV(5), .RST_EN(1'b1)) u_dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
        .cfg_en(cfg_en), .cfg_oneshot(cfg_os), .sync(sync),
        .tick(tick), .usr_clk(usr_clk), .en_status(en_status)
    );

    clock_divider_bank #(.NUM_CH(5), .CNT_W(8), .DEF_DIV(5), .RST_EN(1'b1)) u_dut5 (
        .clk(clk), .reset(reset), .cfg_we(cfg_we5), .cfg_ch(cfg_ch5), .cfg_div(cfg_div),
        .cfg_en(cfg_en), .cfg_oneshot(cfg_os), .sync(sync),
        .tick(tick5), .usr_clk(usr5), .en_status(en5)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Asserts reset between edges; on return the next rising edge is edge 1.
    task automatic do_reset();
        @(posedge clk);
        #3 reset = 1'b0;
        cfg_we = 1'b0;
        cfg_we5 = 1'b0;
        sync = 1'b0;
        @(posedge clk);
        #3 reset = 1'b1;
    endtask

    task automatic write_cfg(input logic [1:0] ch, input logic [7:0] dv, input logic en, input logic os);
        cfg_ch = ch;
        cfg_div = dv;
        cfg_en = en;
        cfg_os = os;
        cfg_we = 1'b1;
        step(1);
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        total++; if (tick !== 4'h0) begin bad++; $display("FAIL reset_tick got=%h exp=0", tick); end
        total++; if (usr_clk !== 4'h0) begin bad++; $display("FAIL reset_usr got=%h exp=0", usr_clk); end
        total++; if (en_status !== 4'hF) begin bad++; $display("FAIL reset_en got=%h exp=f", en_status); end
        #1 reset = 1'b1;
        step(4);
        total++; if (tick !== 4'h0 || usr_clk !== 4'h0) begin bad++; $display("FAIL reset_e4 tick=%h usr=%h exp 0/0", tick, usr_clk); end
        step(1);
        total++; if (tick !== 4'hF || usr_clk !== 4'hF) begin bad++; $display("FAIL reset_e5 tick=%h usr=%h exp f/f", tick, usr_clk); end
        step(1);
        total++; if (tick !== 4'h0 || usr_clk !== 4'hF) begin bad++; $display("FAIL reset_e6 tick=%h usr=%h exp 0/f", tick, usr_clk); end
        step(4);
        total++; if (tick !== 4'hF || usr_clk !== 4'h0) begin bad++; $display("FAIL reset_e10 tick=%h usr=%h exp f/0", tick, usr_clk); end
        $display("test_reset done");
    endtask

    task automatic test_freerun();
        logic [3:0] et, eu;
        do_reset();
        write_cfg(2'd1, 8'd3, 1'b1, 1'b0);
        total++; if (tick[1] !== 1'b0 || usr_clk[1] !== 1'b0) begin bad++; $display("FAIL freerun_wr tick1=%b usr1=%b exp 0/0", tick[1], usr_clk[1]); end
        for (int k = 1; k <= 9; k++) begin
            step(1);
            for (int i = 0; i < 4; i++) begin
                if (i == 1) begin
                    et[i] = ((k % 3) == 0);
                    eu[i] = 1'((k / 3) % 2);
                end else begin
                    et[i] = (((k + 1) % 5) == 0);
                    eu[i] = 1'(((k + 1) / 5) % 2);
                end
            end
            total++; if (tick !== et || usr_clk !== eu) begin bad++; $display("FAIL freerun k=%0d tick=%h usr=%h exp %h/%h", k, tick, usr_clk, et, eu); end
        end
        $display("test_freerun done");
    endtask

    task automatic test_oneshot();
        logic [2:0] got, exp;
        do_reset();
        write_cfg(2'd2, 8'd4, 1'b1, 1'b1);
        for (int k = 1; k <= 50; k++) begin
            step(1);
            got = {tick[2], usr_clk[2], en_status[2]};
            exp = {(k == 4), (k >= 4), (k < 4)};
            total++; if (got !== exp) begin bad++; $display("FAIL oneshot k=%0d tick/usr/en=%b exp=%b", k, got, exp); end
        end
        $display("test_oneshot done");
    endtask

    task automatic test_div1_div0();
        do_reset();
        write_cfg(2'd3, 8'd1, 1'b1, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            step(1);
            total++; if (tick[3] !== 1'b1 || usr_clk[3] !== 1'(k % 2)) begin bad++; $display("FAIL div1 k=%0d tick3=%b usr3=%b exp 1/%0d", k, tick[3], usr_clk[3], k % 2); end
        end
        write_cfg(2'd3, 8'd0, 1'b1, 1'b0);
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) step(1);
            total++; if (tick[3] !== 1'b0 || usr_clk[3] !== 1'b0 || en_status[3] !== 1'b1) begin bad++; $display("FAIL div0 k=%0d tick3=%b usr3=%b en3=%b exp 0/0/1", k, tick[3], usr_clk[3], en_status[3]); end
        end
        write_cfg(2'd3, 8'd2, 1'b1, 1'b0);
        step(1);
        total++; if (tick[3] !== 1'b0) begin bad++; $display("FAIL div2_e1 tick3=%b exp 0", tick[3]); end
        step(1);
        total++; if (tick[3] !== 1'b1 || usr_clk[3] !== 1'b1) begin bad++; $display("FAIL div2_e2 tick3=%b usr3=%b exp 1/1", tick[3], usr_clk[3]); end
        $display("test_div1_div0 done");
    endtask

    task automatic test_sync();
        int dv [4] = '{3, 5, 7, 2};
        logic [3:0] et, eu;
        do_reset();
        write_cfg(2'd0, 8'd3, 1'b1, 1'b0);
        write_cfg(2'd1, 8'd4, 1'b1, 1'b0);
        write_cfg(2'd2, 8'd7, 1'b1, 1'b0);
        write_cfg(2'd3, 8'd2, 1'b1, 1'b0);
        step(4);
        cfg_ch = 2'd1; cfg_div = 8'd5; cfg_en = 1'b1; cfg_os = 1'b0;
        cfg_we = 1'b1; sync = 1'b1;
        step(1);
        cfg_we = 1'b0; sync = 1'b0;
        total++; if (tick !== 4'h0 || usr_clk !== 4'h0 || en_status !== 4'hF) begin bad++; $display("FAIL sync_edge tick=%h usr=%h en=%h exp 0/0/f", tick, usr_clk, en_status); end
        for (int k = 1; k <= 14; k++) begin
            step(1);
            for (int i = 0; i < 4; i++) begin
                et[i] = ((k % dv[i]) == 0);
                eu[i] = 1'((k / dv[i]) % 2);
            end
            total++; if (tick !== et || usr_clk !== eu) begin bad++; $display("FAIL sync k=%0d tick=%h usr=%h exp %h/%h", k, tick, usr_clk, et, eu); end
        end
        $display("test_sync done");
    endtask

    task automatic test_write_tc();
        do_reset();
        step(4);
        write_cfg(2'd0, 8'd5, 1'b1, 1'b0);
        total++; if (tick !== 4'b1110 || usr_clk !== 4'b1110) begin bad++; $display("FAIL wr_tc tick=%h usr=%h exp e/e", tick, usr_clk); end
        step(5);
        total++; if (tick !== 4'hF || usr_clk !== 4'b0001) begin bad++; $display("FAIL wr_tc_next tick=%h usr=%h exp f/1", tick, usr_clk); end
        $display("test_write_tc done");
    endtask

    task automatic test_async_reset();
        do_reset();
        write_cfg(2'd0, 8'd5, 1'b0, 1'b0);
        step(4);
        total++; if (tick !== 4'b1110 || usr_clk !== 4'b1110 || en_status !== 4'b1110) begin bad++; $display("FAIL arst_pre tick=%h usr=%h en=%h exp e/e/e", tick, usr_clk, en_status); end
        #2 reset = 1'b0;
        #1;
        total++; if (tick !== 4'h0 || usr_clk !== 4'h0 || en_status !== 4'hF) begin bad++; $display("FAIL arst_clear tick=%h usr=%h en=%h exp 0/0/f", tick, usr_clk, en_status); end
        #2 reset = 1'b1;
        step(4);
        total++; if (tick !== 4'h0) begin bad++; $display("FAIL arst_e4 tick=%h exp 0", tick); end
        step(1);
        total++; if (tick !== 4'hF || usr_clk !== 4'hF) begin bad++; $display("FAIL arst_e5 tick=%h usr=%h exp f/f", tick, usr_clk); end
        $display("test_async_reset done");
    endtask

    task automatic test_bad_ch();
        do_reset();
        cfg_div = 8'd2; cfg_en = 1'b0; cfg_os = 1'b1;
        cfg_ch5 = 3'd7; cfg_we5 = 1'b1;
        step(1);
        cfg_ch5 = 3'd5;
        step(1);
        cfg_we5 = 1'b0;
        step(3);
        total++; if (tick5 !== 5'h1F || usr5 !== 5'h1F || en5 !== 5'h1F) begin bad++; $display("FAIL bad_ch tick=%h usr=%h en=%h exp 1f/1f/1f", tick5, usr5, en5); end
        cfg_ch5 = 3'd4; cfg_div = 8'd2; cfg_en = 1'b1; cfg_os = 1'b0; cfg_we5 = 1'b1;
        step(1);
        cfg_we5 = 1'b0;
        total++; if (usr5 !== 5'h0F || tick5 !== 5'h00) begin bad++; $display("FAIL ch4_wr tick=%h usr=%h exp 00/0f", tick5, usr5); end
        step(2);
        total++; if (tick5 !== 5'h10 || usr5 !== 5'h1F) begin bad++; $display("FAIL ch4_tick tick=%h usr=%h exp 10/1f", tick5, usr5); end
        $display("test_bad_ch done");
    endtask

    task automatic test_wrap();
        do_reset();
        write_cfg(2'd0, 8'd255, 1'b1, 1'b0);
        step(254);
        total++; if (tick[0] !== 1'b0 || usr_clk[0] !== 1'b0) begin bad++; $display("FAIL wrap_254 tick0=%b usr0=%b exp 0/0", tick[0], usr_clk[0]); end
        step(1);
        total++; if (tick[0] !== 1'b1 || usr_clk[0] !== 1'b1) begin bad++; $display("FAIL wrap_255 tick0=%b usr0=%b exp 1/1", tick[0], usr_clk[0]); end
        step(1);
        total++; if (tick[0] !== 1'b0) begin bad++; $display("FAIL wrap_256 tick0=%b exp 0", tick[0]); end
        step(254);
        total++; if (tick[0] !== 1'b1 || usr_clk[0] !== 1'b0) begin bad++; $display("FAIL wrap_510 tick0=%b usr0=%b exp 1/0", tick[0], usr_clk[0]); end
        $display("test_wrap done");
    endtask

    initial begin
        test_reset();
        test_freerun();
        test_oneshot();
        test_div1_div0();
        test_sync();
        test_write_tc();
        test_async_reset();
        test_bad_ch();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
